tlul_arbiter_2to1: RTL and testbench

- Two-master to one-slave arbiter for the TL-UL bus, 32-bit data.
- Shares one TL-UL slave port between masters m0 and m1. Round-robin on channel A; channel D routed back by a source-tag bit.
- Tracks outstanding transactions per master and throttles each master at MAX.
- Sits between bus masters (core, DMA) and a single peripheral slave.

---
 rtl/tlul_arb_pkg.sv | 15 +
 rtl/tlul_arb_txn_counter.sv | 86 ++++++++
 rtl/tlul_arbiter_2to1.sv | 208 ++++++++++++++++++++
 tb/tb_tlul_arbiter_2to1.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_arb_pkg.sv
// Shared constants and types for the 2:1 TL-UL arbiter.
package tlul_arb_pkg;

    localparam logic [2:0] GET           = 3'd4;
    localparam logic [2:0] PUTFULL       = 3'd0;
    localparam logic [2:0] PUTPARTIAL    = 3'd1;
    localparam logic [2:0] ACCESSACK     = 3'd0;
    localparam logic [2:0] ACCESSACKDATA = 3'd1;

    typedef logic grant_t;

    localparam int unsigned DEFAULT_MAX     = 2;
    localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/tlul_arb_txn_counter.sv
// Per-master outstanding-transaction counter with underflow flag.
// Optional response watchdog under TLUL_ARB_TIMEOUT_EN.
module tlul_arb_txn_counter
    import tlul_arb_pkg::*;
#(
    parameter int unsigned CW  = 5,
    parameter int unsigned MAX = DEFAULT_MAX
`ifdef TLUL_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          a_hs_i,
    input  logic          d_hs_i,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          err_o
`ifdef TLUL_ARB_TIMEOUT_EN
    ,
    output logic          timeout_o
`endif
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Simultaneous request and response cancel out; never wrap either way.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (d_hs_i && (cnt_q == '0)) begin
            err_d = 1'b1;
        end else if (a_hs_i && !d_hs_i && (cnt_q != CW'(MAX))) begin
            cnt_d = cnt_q + CW'(1);
        end else if (d_hs_i && !a_hs_i) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == CW'(MAX));
    assign err_o  = err_q;

`ifdef TLUL_ARB_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          to_q, to_d;

    // Watchdog idles while nothing is owed and restarts on each response.
    always_comb begin
        wd_d = wd_q;
        to_d = to_q | (wd_q == WW'(TIMEOUT));
        if (d_hs_i || (cnt_q == '0)) begin
            wd_d = '0;
        end else if (wd_q != WW'(TIMEOUT)) begin
            wd_d = wd_q + WW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout_o = to_q;
`endif

endmodule

// File: rtl/tlul_arbiter_2to1.sv
// Two-master to one-slave TL-UL arbiter: round-robin A channel with stall lock,
// D channel routed by the top source bit. Optional watchdog: TLUL_ARB_TIMEOUT_EN.
module tlul_arbiter_2to1
    import tlul_arb_pkg::*;
#(
    parameter int unsigned AW  = 32,
    parameter int unsigned RS  = 4,
    parameter int unsigned MAX = DEFAULT_MAX
`ifdef TLUL_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
    input  logic          tilelink_clock_i,
    input  logic          tilelink_reset_i,

    input  logic [2:0]    m0_a_opcode,
    input  logic [2:0]    m0_a_param,
    input  logic [3:0]    m0_a_size,
    input  logic [RS-1:0] m0_a_source,
    input  logic [AW-1:0] m0_a_address,
    input  logic [3:0]    m0_a_mask,
    input  logic [31:0]   m0_a_data,
    input  logic          m0_a_corrupt,
    input  logic          m0_a_valid,
    output logic          m0_a_ready,
    output logic [2:0]    m0_d_opcode,
    output logic [1:0]    m0_d_param,
    output logic [3:0]    m0_d_size,
    output logic [RS-1:0] m0_d_source,
    output logic          m0_d_denied,
    output logic [31:0]   m0_d_data,
    output logic          m0_d_corrupt,
    output logic          m0_d_valid,
    input  logic          m0_d_ready,

    input  logic [2:0]    m1_a_opcode,
    input  logic [2:0]    m1_a_param,
    input  logic [3:0]    m1_a_size,
    input  logic [RS-1:0] m1_a_source,
    input  logic [AW-1:0] m1_a_address,
    input  logic [3:0]    m1_a_mask,
    input  logic [31:0]   m1_a_data,
    input  logic          m1_a_corrupt,
    input  logic          m1_a_valid,
    output logic          m1_a_ready,
    output logic [2:0]    m1_d_opcode,
    output logic [1:0]    m1_d_param,
    output logic [3:0]    m1_d_size,
    output logic [RS-1:0] m1_d_source,
    output logic          m1_d_denied,
    output logic [31:0]   m1_d_data,
    output logic          m1_d_corrupt,
    output logic          m1_d_valid,
    input  logic          m1_d_ready,

    output logic [2:0]    s_a_opcode,
    output logic [2:0]    s_a_param,
    output logic [3:0]    s_a_size,
    output logic [RS:0]   s_a_source,
    output logic [AW-1:0] s_a_address,
    output logic [3:0]    s_a_mask,
    output logic [31:0]   s_a_data,
    output logic          s_a_corrupt,
    output logic          s_a_valid,
    input  logic          s_a_ready,
    input  logic [2:0]    s_d_opcode,
    input  logic [1:0]    s_d_param,
    input  logic [3:0]    s_d_size,
    input  logic [RS:0]   s_d_source,
    input  logic          s_d_denied,
    input  logic [31:0]   s_d_data,
    input  logic          s_d_corrupt,
    input  logic          s_d_valid,
    output logic          s_d_ready,

    output logic [RS:0]   outstanding0_o,
    output logic [RS:0]   outstanding1_o,
    output logic          protocol_err_o
`ifdef TLUL_ARB_TIMEOUT_EN
    ,
    output logic          timeout_o
`endif
);

    logic   full0, full1, err0, err1;
    logic   elig0, elig1;
    logic   a_hs, d_idx, d_hs0, d_hs1;
    grant_t sel;
    grant_t lock_idx_q, lock_idx_d;
    grant_t rr_last_q, rr_last_d;
    logic   lock_q, lock_d;

    assign elig0 = m0_a_valid & ~full0;
    assign elig1 = m1_a_valid & ~full1;

    // A stalled request keeps its grant so the slave sees stable fields.
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = lock_idx_q;
        end else if (elig0 && elig1) begin
            sel = ~rr_last_q;
        end else if (elig1) begin
            sel = 1'b1;
        end
    end

    assign s_a_valid   = ~tilelink_reset_i & (sel ? elig1 : elig0);
    assign a_hs        = s_a_valid & s_a_ready;
    assign m0_a_ready  = a_hs & ~sel;
    assign m1_a_ready  = a_hs & sel;

    assign s_a_opcode  = sel ? m1_a_opcode  : m0_a_opcode;
    assign s_a_param   = sel ? m1_a_param   : m0_a_param;
    assign s_a_size    = sel ? m1_a_size    : m0_a_size;
    assign s_a_source  = {sel, (sel ? m1_a_source : m0_a_source)};
    assign s_a_address = sel ? m1_a_address : m0_a_address;
    assign s_a_mask    = sel ? m1_a_mask    : m0_a_mask;
    assign s_a_data    = sel ? m1_a_data    : m0_a_data;
    assign s_a_corrupt = sel ? m1_a_corrupt : m0_a_corrupt;

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_last_d  = rr_last_q;
        if (a_hs) begin
            lock_d    = 1'b0;
            rr_last_d = sel;
        end else if (s_a_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
    end

    always_ff @(posedge tilelink_clock_i) begin
        if (tilelink_reset_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
            rr_last_q  <= 1'b1;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_last_q  <= rr_last_d;
        end
    end

    // Response path is unbuffered; the top source bit names the master.
    assign d_idx        = s_d_source[RS];
    assign m0_d_valid   = ~tilelink_reset_i & s_d_valid & ~d_idx;
    assign m1_d_valid   = ~tilelink_reset_i & s_d_valid & d_idx;
    assign s_d_ready    = ~tilelink_reset_i & (d_idx ? m1_d_ready : m0_d_ready);
    assign d_hs0        = m0_d_valid & m0_d_ready;
    assign d_hs1        = m1_d_valid & m1_d_ready;

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source[RS-1:0];
    assign m0_d_denied  = s_d_denied;
    assign m0_d_data    = s_d_data;
    assign m0_d_corrupt = s_d_corrupt;
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source[RS-1:0];
    assign m1_d_denied  = s_d_denied;
    assign m1_d_data    = s_d_data;
    assign m1_d_corrupt = s_d_corrupt;

`ifdef TLUL_ARB_TIMEOUT_EN
    logic to0, to1;
`endif

    tlul_arb_txn_counter #(
        .CW(RS + 1), .MAX(MAX)
`ifdef TLUL_ARB_TIMEOUT_EN
        , .TIMEOUT(TIMEOUT)
`endif
    ) u_cnt0 (
        .clk_i(tilelink_clock_i), .rst_i(tilelink_reset_i),
        .a_hs_i(m0_a_ready), .d_hs_i(d_hs0),
        .cnt_o(outstanding0_o), .full_o(full0), .err_o(err0)
`ifdef TLUL_ARB_TIMEOUT_EN
        , .timeout_o(to0)
`endif
    );

    tlul_arb_txn_counter #(
        .CW(RS + 1), .MAX(MAX)
`ifdef TLUL_ARB_TIMEOUT_EN
        , .TIMEOUT(TIMEOUT)
`endif
    ) u_cnt1 (
        .clk_i(tilelink_clock_i), .rst_i(tilelink_reset_i),
        .a_hs_i(m1_a_ready), .d_hs_i(d_hs1),
        .cnt_o(outstanding1_o), .full_o(full1), .err_o(err1)
`ifdef TLUL_ARB_TIMEOUT_EN
        , .timeout_o(to1)
`endif
    );

    assign protocol_err_o = err0 | err1;
`ifdef TLUL_ARB_TIMEOUT_EN
    assign timeout_o = to0 | to1;
`endif

endmodule

// File: tb/tb_tlul_arbiter_2to1.sv
// Bench for tlul_arbiter_2to1: vector table, directed corner sequences and a
// randomized run against a queue-based model of the bus.
module tb_tlul_arbiter_2to1;
    import tlul_arb_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned RS  = 4;
    localparam int unsigned MAX = 2;
    localparam int unsigned SW  = RS + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]    ma_opcode  [2];
    logic [2:0]    ma_param   [2];
    logic [3:0]    ma_size    [2];
    logic [RS-1:0] ma_source  [2];
    logic [AW-1:0] ma_address [2];
    logic [3:0]    ma_mask    [2];
    logic [31:0]   ma_data    [2];
    logic          ma_corrupt [2];
    logic          ma_valid   [2];
    logic          ma_ready   [2];
    logic [2:0]    md_opcode  [2];
    logic [1:0]    md_param   [2];
    logic [3:0]    md_size    [2];
    logic [RS-1:0] md_source  [2];
    logic          md_denied  [2];
    logic [31:0]   md_data    [2];
    logic          md_corrupt [2];
    logic          md_valid   [2];
    logic          md_ready   [2];

    logic [2:0]    s_a_opcode, s_a_param;
    logic [3:0]    s_a_size, s_a_mask;
    logic [SW-1:0] s_a_source;
    logic [AW-1:0] s_a_address;
    logic [31:0]   s_a_data;
    logic          s_a_corrupt, s_a_valid, s_a_ready;
    logic [2:0]    s_d_opcode;
    logic [1:0]    s_d_param;
    logic [3:0]    s_d_size;
    logic [SW-1:0] s_d_source;
    logic [31:0]   s_d_data;
    logic          s_d_denied, s_d_corrupt, s_d_valid, s_d_ready;
    logic [SW-1:0] outstanding0_o, outstanding1_o;
    logic          protocol_err_o;
`ifdef TLUL_ARB_TIMEOUT_EN
    logic          timeout_o;
`endif

    tlul_arbiter_2to1 #(
        .AW(AW), .RS(RS), .MAX(MAX)
`ifdef TLUL_ARB_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .tilelink_clock_i(clk), .tilelink_reset_i(rst),
        .m0_a_opcode(ma_opcode[0]), .m0_a_param(ma_param[0]), .m0_a_size(ma_size[0]),
        .m0_a_source(ma_source[0]), .m0_a_address(ma_address[0]), .m0_a_mask(ma_mask[0]),
        .m0_a_data(ma_data[0]), .m0_a_corrupt(ma_corrupt[0]), .m0_a_valid(ma_valid[0]),
        .m0_a_ready(ma_ready[0]),
        .m0_d_opcode(md_opcode[0]), .m0_d_param(md_param[0]), .m0_d_size(md_size[0]),
        .m0_d_source(md_source[0]), .m0_d_denied(md_denied[0]), .m0_d_data(md_data[0]),
        .m0_d_corrupt(md_corrupt[0]), .m0_d_valid(md_valid[0]), .m0_d_ready(md_ready[0]),
        .m1_a_opcode(ma_opcode[1]), .m1_a_param(ma_param[1]), .m1_a_size(ma_size[1]),
        .m1_a_source(ma_source[1]), .m1_a_address(ma_address[1]), .m1_a_mask(ma_mask[1]),
        .m1_a_data(ma_data[1]), .m1_a_corrupt(ma_corrupt[1]), .m1_a_valid(ma_valid[1]),
        .m1_a_ready(ma_ready[1]),
        .m1_d_opcode(md_opcode[1]), .m1_d_param(md_param[1]), .m1_d_size(md_size[1]),
        .m1_d_source(md_source[1]), .m1_d_denied(md_denied[1]), .m1_d_data(md_data[1]),
        .m1_d_corrupt(md_corrupt[1]), .m1_d_valid(md_valid[1]), .m1_d_ready(md_ready[1]),
        .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
        .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
        .s_a_data(s_a_data), .s_a_corrupt(s_a_corrupt), .s_a_valid(s_a_valid),
        .s_a_ready(s_a_ready),
        .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
        .s_d_source(s_d_source), .s_d_denied(s_d_denied), .s_d_data(s_d_data),
        .s_d_corrupt(s_d_corrupt), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
        .outstanding0_o(outstanding0_o), .outstanding1_o(outstanding1_o),
        .protocol_err_o(protocol_err_o)
`ifdef TLUL_ARB_TIMEOUT_EN
        , .timeout_o(timeout_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            ma_opcode[i] = GET; ma_param[i] = '0; ma_size[i] = 4'd2;
            ma_source[i] = '0; ma_address[i] = '0; ma_mask[i] = 4'hf;
            ma_data[i] = '0; ma_corrupt[i] = 1'b0; ma_valid[i] = 1'b0;
            md_ready[i] = 1'b0;
        end
        s_a_ready = 1'b0;
        s_d_opcode = ACCESSACKDATA; s_d_param = '0; s_d_size = 4'd2;
        s_d_source = '0; s_d_data = '0; s_d_denied = 1'b0; s_d_corrupt = 1'b0;
        s_d_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    // Inputs: m0v m1v s_a_ready s_d_valid s_d_src_msb m0_d_ready m1_d_ready
    // Expected: s_a_valid src_msb m0_a_ready m1_a_ready m0_d_valid m1_d_valid s_d_ready
    typedef struct packed {
        logic m0v, m1v, sar, sdv, sdmsb, m0dr, m1dr;
        logic e_sav, e_msb, e_m0r, e_m1r, e_m0dv, e_m1dv, e_sdr;
    } vec_t;
    vec_t vecs [7];

    logic          exp_g, prev_g;
    int            c0, c1, stalled, last, pick, sel_m;
    logic          e0, e1, ev, a_hs_m, d_hs_m, d_idx_m;
    logic [SW-1:0] pend [$];
    logic [SW-1:0] new_tag;
    int            to_seen;

    initial begin
        vecs[0] = 14'b1110000_1010000;
        vecs[1] = 14'b0110000_1101000;
        vecs[2] = 14'b1000000_1000000;
        vecs[3] = 14'b0010000_0000000;
        vecs[4] = 14'b0001110_0000010;
        vecs[5] = 14'b0001010_0000101;
        vecs[6] = 14'b0000101_0000001;

        idle();
        tick();
        #2;
        check("rst_s_a_valid", s_a_valid, 1'b0);
        check("rst_s_d_ready", s_d_ready, 1'b0);
        rst = 1'b0;
        check("rst_cnt0", outstanding0_o, '0);
        check("rst_cnt1", outstanding1_o, '0);
        check("rst_err", protocol_err_o, 1'b0);

        // Single-cycle behaviour from the reset state.
        for (int r = 0; r < 7; r++) begin
            do_reset();
            ma_valid[0] = vecs[r].m0v; ma_valid[1] = vecs[r].m1v;
            ma_source[0] = 4'h3; ma_source[1] = 4'h9;
            s_a_ready = vecs[r].sar; s_d_valid = vecs[r].sdv;
            s_d_source = {vecs[r].sdmsb, RS'(r)};
            md_ready[0] = vecs[r].m0dr; md_ready[1] = vecs[r].m1dr;
            #2;
            check("vec_s_a_valid", s_a_valid, vecs[r].e_sav);
            if (vecs[r].e_sav)
                check("vec_s_a_source", s_a_source, {vecs[r].e_msb, (vecs[r].e_msb ? 4'h9 : 4'h3)});
            check("vec_m0_a_ready", ma_ready[0], vecs[r].e_m0r);
            check("vec_m1_a_ready", ma_ready[1], vecs[r].e_m1r);
            check("vec_m0_d_valid", md_valid[0], vecs[r].e_m0dv);
            check("vec_m1_d_valid", md_valid[1], vecs[r].e_m1dv);
            check("vec_s_d_ready", s_d_ready, vecs[r].e_sdr);
            check("vec_d_source", md_source[1], RS'(r));
        end

        // Both masters always requesting: grants alternate, slave answers next cycle.
        do_reset();
        exp_g = 1'b0; prev_g = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ma_valid[0] = 1'b1; ma_valid[1] = 1'b1; s_a_ready = 1'b1;
            md_ready[0] = 1'b1; md_ready[1] = 1'b1;
            s_d_valid = (k > 0); s_d_source = {prev_g, 4'h0};
            #2;
            check("alt_msb", s_a_source[RS], exp_g);
            check("alt_ready", exp_g ? ma_ready[1] : ma_ready[0], 1'b1);
            check("alt_cnt_le1", (outstanding0_o <= 1) && (outstanding1_o <= 1), 1'b1);
            prev_g = exp_g; exp_g = ~exp_g;
            tick();
        end

        // Stalled m0 keeps the grant even when m1 shows up and round-robin favours m1.
        do_reset();
        ma_valid[0] = 1'b1; ma_address[0] = 32'h50; s_a_ready = 1'b1;
        tick();
        ma_address[0] = 32'h100; ma_address[1] = 32'h200; s_a_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            ma_valid[1] = (k >= 2);
            s_a_ready = (k == 4);
            #2;
            check("lock_s_a_valid", s_a_valid, 1'b1);
            check("lock_address", s_a_address, 32'h100);
            check("lock_m1_ready", ma_ready[1], 1'b0);
            check("lock_m0_ready", ma_ready[0], (k == 4));
            tick();
        end
        #2;
        check("lock_next_m1", ma_ready[1], 1'b1);
        check("lock_next_addr", s_a_address, 32'h200);
        tick();
        ma_valid[1] = 1'b0;
        #2;
        check("max_cnt0", outstanding0_o, SW'(2));
        check("max_blocked", s_a_valid, 1'b0);
        s_d_valid = 1'b1; s_d_source = {1'b0, 4'h0}; md_ready[0] = 1'b1;
        tick();
        s_d_valid = 1'b0;
        #2;
        check("max_cnt0_after_d", outstanding0_o, SW'(1));
        check("max_regrant", ma_ready[0], 1'b1);
        tick();
        ma_valid[0] = 1'b0; s_a_ready = 1'b0; md_ready[0] = 1'b0;

        // Response to m1 held by backpressure.
        s_d_valid = 1'b1; s_d_source = {1'b1, 4'h5}; md_ready[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            md_ready[1] = (k == 2);
            #2;
            check("dstall_m1_valid", md_valid[1], 1'b1);
            check("dstall_m0_valid", md_valid[0], 1'b0);
            check("dstall_source", md_source[1], 4'h5);
            check("dstall_s_d_ready", s_d_ready, (k == 2));
            check("dstall_cnt1", outstanding1_o, SW'(1));
            tick();
        end
        s_d_valid = 1'b0;
        #2;
        check("dstall_cnt1_after", outstanding1_o, '0);

        // Response with nothing outstanding is a sticky protocol error.
        do_reset();
        s_d_valid = 1'b1; s_d_source = '0; md_ready[0] = 1'b1;
        tick();
        s_d_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("perr_sticky", protocol_err_o, 1'b1);
            check("perr_cnt0", outstanding0_o, '0);
            tick();
        end

        // Reset while locked.
        do_reset();
        ma_valid[0] = 1'b1; s_a_ready = 1'b1;
        tick();
        s_a_ready = 1'b0;
        tick();
        rst = 1'b1; ma_valid[1] = 1'b1;
        s_d_valid = 1'b1; s_d_source = '0; md_ready[0] = 1'b1;
        #2;
        check("rlock_s_a_valid", s_a_valid, 1'b0);
        check("rlock_m0_ready", ma_ready[0], 1'b0);
        check("rlock_m0_d_valid", md_valid[0], 1'b0);
        check("rlock_s_d_ready", s_d_ready, 1'b0);
        tick();
        rst = 1'b0; s_d_valid = 1'b0; s_a_ready = 1'b1;
        #2;
        check("rlock_cnt0", outstanding0_o, '0);
        check("rlock_err", protocol_err_o, 1'b0);
        check("rlock_tie_m0", s_a_source[RS], 1'b0);
        check("rlock_m0_ready2", ma_ready[0], 1'b1);

        // Randomized traffic against a queue of outstanding slave-side tags.
        do_reset();
        pend.delete();
        stalled = -1; last = 1; a_hs_m = 1'b0; d_hs_m = 1'b0; sel_m = 0; pick = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!ma_valid[i] && ($urandom_range(0, 2) != 0)) begin
                    ma_valid[i]   = 1'b1;
                    ma_opcode[i]  = ($urandom_range(0, 1) != 0) ? GET : PUTFULL;
                    ma_address[i] = $urandom;
                    ma_data[i]    = $urandom;
                    ma_source[i]  = RS'($urandom);
                end
                md_ready[i] = ($urandom_range(0, 2) != 0);
            end
            s_a_ready = ($urandom_range(0, 3) != 0);
            if (!s_d_valid && (pend.size() > 0) && ($urandom_range(0, 1) != 0)) begin
                pick       = $urandom_range(0, pend.size() - 1);
                s_d_valid  = 1'b1;
                s_d_source = pend[pick];
                s_d_data   = $urandom;
            end
            #2;
            c0 = 0; c1 = 0;
            foreach (pend[k]) if (pend[k][RS]) c1++; else c0++;
            e0 = ma_valid[0] && (c0 < MAX);
            e1 = ma_valid[1] && (c1 < MAX);
            if (stalled >= 0)   sel_m = stalled;
            else if (e0 && e1)  sel_m = 1 - last;
            else if (e1)        sel_m = 1;
            else                sel_m = 0;
            ev = (sel_m == 1) ? e1 : e0;
            check("rnd_s_a_valid", s_a_valid, ev);
            if (ev) begin
                check("rnd_s_a_source", s_a_source, {sel_m[0], ma_source[sel_m]});
                check("rnd_s_a_address", s_a_address, ma_address[sel_m]);
                check("rnd_s_a_opcode", s_a_opcode, ma_opcode[sel_m]);
            end
            check("rnd_m0_a_ready", ma_ready[0], ev && s_a_ready && (sel_m == 0));
            check("rnd_m1_a_ready", ma_ready[1], ev && s_a_ready && (sel_m == 1));
            d_idx_m = s_d_source[RS];
            check("rnd_m0_d_valid", md_valid[0], s_d_valid && !d_idx_m);
            check("rnd_m1_d_valid", md_valid[1], s_d_valid && d_idx_m);
            check("rnd_s_d_ready", s_d_ready, d_idx_m ? md_ready[1] : md_ready[0]);
            check("rnd_d_data", md_data[0], s_d_data);
            check("rnd_cnt0", outstanding0_o, SW'(c0));
            check("rnd_cnt1", outstanding1_o, SW'(c1));
            check("rnd_err", protocol_err_o, 1'b0);
            a_hs_m  = ev && s_a_ready;
            d_hs_m  = s_d_valid && (d_idx_m ? md_ready[1] : md_ready[0]);
            new_tag = {sel_m[0], ma_source[sel_m]};
            tick();
            if (a_hs_m) begin
                pend.push_back(new_tag);
                last = sel_m;
                ma_valid[sel_m] = 1'b0;
                stalled = -1;
            end else begin
                stalled = ev ? sel_m : -1;
            end
            if (d_hs_m) begin
                pend.delete(pick);
                s_d_valid = 1'b0;
            end
        end

`ifdef TLUL_ARB_TIMEOUT_EN
        // Watchdog fires on a response that never comes, and stays quiet otherwise.
        for (int run = 0; run < 2; run++) begin
            do_reset();
            ma_valid[1] = 1'b1; s_a_ready = 1'b1;
            tick();
            ma_valid[1] = 1'b0; s_a_ready = 1'b0;
            to_seen = 0;
            for (int k = 1; k <= 14; k++) begin
                if (run == 1 && k == 7) begin
                    s_d_valid = 1'b1; s_d_source = {1'b1, 4'h0}; md_ready[1] = 1'b1;
                end else begin
                    s_d_valid = 1'b0;
                end
                #2;
                if (k <= 6) check("wd_early_quiet", timeout_o, 1'b0);
                if (timeout_o) to_seen = 1;
                tick();
            end
            check(run == 0 ? "wd_fires" : "wd_control_quiet", to_seen, (run == 0) ? 1 : 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
